// File: rtl/cpu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared CPU control definitions used by the multiply sequencer.
//   mult_state_t          : sequencer state encoding (IDLE / RUN / DONE)
//   MULT_LATENCY_DEFAULT  : default multiplier occupancy of EX, in cycles
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mult_state_t;

    // Legal range for MULT_LATENCY is 2..8.
    localparam int MULT_LATENCY_DEFAULT = 4;

endpackage : cpu_ctrl_pkg

// File: rtl/mult_cycle_counter.sv
// ----------------------------------------------------------------------------
// mult_cycle_counter
// Cycle counter for the multiply sequencer. Counts the cycles a multiply has
// occupied EX; saturates at MULT_LATENCY-1 and never wraps.
// Ports:
//   clk    : clock, rising edge
//   arst_n : asynchronous active-low reset (count -> 0)
//   clear  : synchronous clear to 0 (highest priority)
//   load   : load the count with 1 (first cycle of a multiply)
//   inc    : increment, holding at MULT_LATENCY-1
//   count  : current count, $clog2(MULT_LATENCY) bits
// ----------------------------------------------------------------------------
module mult_cycle_counter #(
    parameter int MULT_LATENCY = 4
) (
    input  logic                            clk,
    input  logic                            arst_n,
    input  logic                            clear,
    input  logic                            load,
    input  logic                            inc,
    output logic [$clog2(MULT_LATENCY)-1:0] count
);

    localparam int               CNT_W   = $clog2(MULT_LATENCY);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MULT_LATENCY - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= CNT_W'(1);
        end else if (inc && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule : mult_cycle_counter

// File: rtl/mult_sequencer.sv
// ----------------------------------------------------------------------------
// mult_sequencer
// Control FSM for a multi-cycle multiplier sitting in the EX stage. Stalls the
// front of the pipe while the multiplier runs, flags the result for EX/MEM
// capture and holds it (DONE) while the downstream stage is busy.
//
// Optional feature: define MULT_ZERO_BYPASS_EN to complete a multiply with a
// zero operand in its first cycle, selecting constant zero as the result.
// Without it operand_zero_ex is ignored and mult_zero_sel stays 0.
//
// Ports:
//   clk               : clock, rising edge
//   arst_n            : asynchronous active-low reset; deassertion is expected
//                       to be synchronous to clk (from the system reset sync)
//   mult_valid_ex     : multiply instruction present in EX
//   operand_zero_ex   : one of the multiplier operands is zero
//   flush_ex          : squash the instruction in EX (beats start/completion)
//   ex_hold           : downstream stage cannot accept EX output this cycle
//   mult_stall        : hold PC, IF/ID, ID/EX; bubble into EX/MEM
//   mult_stage_en     : advance multiplier internal pipeline registers
//   mult_result_valid : multiplier result valid for EX/MEM capture
//   mult_zero_sel     : select constant zero as the multiply result
//   mult_busy         : state is not IDLE
// ----------------------------------------------------------------------------
module mult_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MULT_LATENCY = MULT_LATENCY_DEFAULT
) (
    input  logic clk,
    input  logic arst_n,
    input  logic mult_valid_ex,
    input  logic operand_zero_ex,
    input  logic flush_ex,
    input  logic ex_hold,
    output logic mult_stall,
    output logic mult_stage_en,
    output logic mult_result_valid,
    output logic mult_zero_sel,
    output logic mult_busy
);

    localparam int               CNT_W    = $clog2(MULT_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LATENCY - 1);

    mult_state_t      state_reg;
    mult_state_t      state_next;
    logic             cnt_load;
    logic             cnt_inc;
    logic             cnt_clear;
    logic [CNT_W-1:0] cnt_value;
    logic             start;
    logic             zero_op;    // start qualifies for the zero bypass
    logic             zero_done;  // DONE is holding a bypassed zero result

`ifdef MULT_ZERO_BYPASS_EN
    logic zero_hold_reg;
    logic zero_hold_next;

    assign zero_op   = operand_zero_ex;
    assign zero_done = zero_hold_reg;

    // Remembers that the result parked in DONE came from the zero bypass, so
    // mult_zero_sel stays asserted for as long as the result is held.
    always_comb begin
        zero_hold_next = 1'b0;
        if (!flush_ex) begin
            if ((state_reg == IDLE) && start && zero_op) begin
                zero_hold_next = 1'b1;
            end else if (state_reg == DONE) begin
                zero_hold_next = zero_hold_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            zero_hold_reg <= 1'b0;
        end else begin
            zero_hold_reg <= zero_hold_next;
        end
    end
`else
    logic unused_operand_zero;

    assign unused_operand_zero = operand_zero_ex;
    // Both constant: mult_zero_sel folds to a tie-off.
    assign zero_op   = 1'b0;
    assign zero_done = 1'b0;
`endif

    // Gating with arst_n keeps every output low while reset is asserted,
    // even though IDLE decodes mult_valid_ex combinationally.
    assign start = mult_valid_ex && !flush_ex && arst_n;

    mult_cycle_counter #(
        .MULT_LATENCY(MULT_LATENCY)
    ) u_cycle_counter (
        .clk    (clk),
        .arst_n (arst_n),
        .clear  (cnt_clear),
        .load   (cnt_load),
        .inc    (cnt_inc),
        .count  (cnt_value)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        mult_stall        = 1'b0;
        mult_stage_en     = 1'b0;
        mult_result_valid = 1'b0;
        mult_zero_sel     = 1'b0;
        cnt_load          = 1'b0;
        cnt_inc           = 1'b0;
        cnt_clear         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (zero_op) begin
                        // Result is known to be zero: finish now, skip RUN.
                        mult_result_valid = 1'b1;
                        mult_zero_sel     = 1'b1;
                        state_next        = ex_hold ? DONE : IDLE;
                    end else begin
                        mult_stall    = 1'b1;
                        mult_stage_en = 1'b1;
                        cnt_load      = 1'b1;
                        state_next    = RUN;
                    end
                end
            end
            RUN: begin
                mult_stage_en = 1'b1;
                cnt_inc       = 1'b1;
                if (cnt_value == CNT_LAST) begin
                    // Stall drops here so a new multiply can enter EX next
                    // cycle; it is not accepted until IDLE is reached.
                    mult_result_valid = 1'b1;
                    state_next        = ex_hold ? DONE : IDLE;
                end else begin
                    mult_stall = 1'b1;
                end
            end
            DONE: begin
                mult_result_valid = 1'b1;
                mult_zero_sel     = zero_done;
                if (!ex_hold) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Squash overrides everything decoded above.
        if (flush_ex) begin
            state_next        = IDLE;
            mult_stall        = 1'b0;
            mult_stage_en     = 1'b0;
            mult_result_valid = 1'b0;
            mult_zero_sel     = 1'b0;
            cnt_load          = 1'b0;
            cnt_inc           = 1'b0;
            cnt_clear         = 1'b1;
        end
    end

    assign mult_busy = (state_reg != IDLE);

endmodule : mult_sequencer
